// File: rtl/dmem_line_ctrl_pkg.sv
// Shared types and default sizing for the line-oriented data memory controller.
// The bench and the RTL both import this package.
package dmem_line_ctrl_pkg;

   typedef enum logic [1:0] {DM_IDLE, DM_WRITE, DM_READ, DM_RESP} dmem_state_e;

   localparam int DM_XLEN      = 32;
   localparam int DM_BLK_SIZE  = 128;
   localparam int DM_MEM_WORDS = 16384;

   function automatic int lineBeats(input int xlen, input int blkSize);
      return blkSize / xlen;
   endfunction

   localparam int DM_BEATS = lineBeats(DM_XLEN, DM_BLK_SIZE);
   localparam int DM_AW    = $clog2(DM_MEM_WORDS);

endpackage

// File: rtl/dmem_line_ctrl_if.sv
// Request/response bundle between the data cache (master) and the line controller (slave).
interface dmem_line_ctrl_if
   import dmem_line_ctrl_pkg::*;
#(
   parameter int XLEN     = DM_XLEN,
   parameter int BLK_SIZE = DM_BLK_SIZE
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_rw_i;
   logic                  req_uncached_i;
   logic [XLEN-1:0]       req_addr_i;
   logic [XLEN/8-1:0]     req_wstrb_i;
   logic [BLK_SIZE-1:0]   req_data_i;
   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [BLK_SIZE-1:0]   res_data_o;

   modport master (
      output req_valid_i, req_rw_i, req_uncached_i, req_addr_i, req_wstrb_i, req_data_i,
      output res_ready_i,
      input  req_ready_o, res_valid_o, res_data_o
   );

   modport slave (
      input  req_valid_i, req_rw_i, req_uncached_i, req_addr_i, req_wstrb_i, req_data_i,
      input  res_ready_i,
      output req_ready_o, res_valid_o, res_data_o
   );

endinterface

// File: rtl/dmem_line_ctrl_sram_1p.sv
// Single-port SRAM, synchronous read with one cycle latency, per-byte write enables.
module dmem_line_ctrl_sram_1p #(
   parameter int    XLEN      = 32,
   parameter int    MEM_WORDS = 16384,
   parameter string INIT_FILE = "",
   localparam int   AW        = $clog2(MEM_WORDS)
) (
   input  logic              clk_i,
   input  logic              i_en,
   input  logic [XLEN/8-1:0] i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   output logic [XLEN-1:0]   o_rdata
);

   logic [XLEN-1:0] r_mem [MEM_WORDS];
   logic [XLEN-1:0] r_rdata;

   // A write cycle also returns the old word; the controller never reads on write beats.
   always_ff @(posedge clk_i) begin
      if (i_en) begin
         for (int b = 0; b < XLEN/8; b++) begin
            if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_line_ctrl.sv
// Line refill / write-back / uncached word controller in front of a single-port SRAM.
// One request at a time: accept, stream the beats, hold the response until taken.
module dmem_line_ctrl
   import dmem_line_ctrl_pkg::*;
#(
   parameter int    XLEN      = DM_XLEN,
   parameter int    BLK_SIZE  = DM_BLK_SIZE,
   parameter int    MEM_WORDS = DM_MEM_WORDS,
   parameter string INIT_FILE = ""
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   dmem_line_ctrl_if.slave bus
);

   localparam int BEATS = lineBeats(XLEN, BLK_SIZE);
   localparam int AW    = $clog2(MEM_WORDS);
   localparam int BW    = $clog2(BEATS + 1);
   localparam int SW    = XLEN / 8;
   localparam logic [AW-1:0] LINE_MASK = AW'(BEATS - 1);

   dmem_state_e         r_state;
   logic                r_reqReady;
   logic                r_resValid;
   logic [BLK_SIZE-1:0] r_resData;
   logic [BLK_SIZE-1:0] r_data;
   logic [BW-1:0]       r_beat;
   logic                r_uncached;
   logic [AW-1:0]       r_wordBase;
   logic [SW-1:0]       r_wstrb;

   logic [AW-1:0]       w_addrWord;
   logic [AW-1:0]       w_acceptBase;
   logic [BW-1:0]       w_nBeats;
   logic [BW-1:0]       w_lastBeat;
   logic [BW-1:0]       w_capIdx;
   logic                w_sramEn;
   logic [SW-1:0]       w_sramWe;
   logic [AW-1:0]       w_sramAddr;
   logic [XLEN-1:0]     w_sramWdata;
   logic [XLEN-1:0]     w_sramRdata;

   // Line requests snap to the line's first word; the SRAM depth wraps the index for free.
   assign w_addrWord   = bus.req_addr_i[AW+1:2];
   assign w_acceptBase = bus.req_uncached_i ? w_addrWord : (w_addrWord & ~LINE_MASK);
   assign w_nBeats     = r_uncached ? BW'(1) : BW'(BEATS);
   assign w_lastBeat   = w_nBeats - BW'(1);
   assign w_capIdx     = r_beat - BW'(1);

   assign w_sramEn    = (r_state == DM_WRITE) || ((r_state == DM_READ) && (r_beat < w_nBeats));
   assign w_sramWe    = (r_state == DM_WRITE) ? (r_uncached ? r_wstrb : {SW{1'b1}}) : '0;
   assign w_sramAddr  = r_wordBase + AW'(r_beat);
   assign w_sramWdata = r_data[XLEN*int'(r_beat) +: XLEN];

   dmem_line_ctrl_sram_1p #(
      .XLEN      (XLEN),
      .MEM_WORDS (MEM_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_sram (
      .clk_i   (clk_i),
      .i_en    (w_sramEn),
      .i_we    (w_sramWe),
      .i_addr  (w_sramAddr),
      .i_wdata (w_sramWdata),
      .o_rdata (w_sramRdata)
   );

   // READ runs one extra cycle: beat k issues word k and captures word k-1 from the SRAM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= DM_IDLE;
         r_reqReady <= 1'b1;
         r_resValid <= 1'b0;
         r_resData  <= '0;
         r_data     <= '0;
         r_beat     <= '0;
         r_uncached <= 1'b0;
         r_wordBase <= '0;
         r_wstrb    <= '0;
      end else begin
         case (r_state)
            DM_IDLE: begin
               if (bus.req_valid_i) begin
                  r_uncached <= bus.req_uncached_i;
                  r_wordBase <= w_acceptBase;
                  r_wstrb    <= bus.req_wstrb_i;
                  r_data     <= bus.req_data_i;
                  r_beat     <= '0;
                  r_resData  <= '0;
                  r_reqReady <= 1'b0;
                  r_state    <= bus.req_rw_i ? DM_WRITE : DM_READ;
               end
            end
            DM_WRITE: begin
               if (r_beat == w_lastBeat) begin
                  r_beat     <= '0;
                  r_resValid <= 1'b1;
                  r_state    <= DM_RESP;
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            DM_READ: begin
               if (r_beat != '0) r_resData[XLEN*int'(w_capIdx) +: XLEN] <= w_sramRdata;
               if (r_beat == w_nBeats) begin
                  r_beat     <= '0;
                  r_resValid <= 1'b1;
                  r_state    <= DM_RESP;
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            DM_RESP: begin
               if (bus.res_ready_i) begin
                  r_resValid <= 1'b0;
                  r_reqReady <= 1'b1;
                  r_state    <= DM_IDLE;
               end
            end
            default: r_state <= DM_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = r_reqReady;
   assign bus.res_valid_o = r_resValid;
   assign bus.res_data_o  = r_resData;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed bench for dmem_line_ctrl: latency, data, stall, wrap, reset abort and held-valid cases.
module tb_dmem_line_ctrl;
   import dmem_line_ctrl_pkg::*;

   localparam int XLEN = DM_XLEN;
   localparam int BLK  = DM_BLK_SIZE;
   localparam int MW   = DM_MEM_WORDS;

   localparam logic [BLK-1:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

   logic clk = 1'b0;
   logic rst_n;
   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;
   int   acceptEvents = 0;

   always #5 clk = ~clk;

   dmem_line_ctrl_if #(.XLEN(XLEN), .BLK_SIZE(BLK)) bus ();

   dmem_line_ctrl #(.XLEN(XLEN), .BLK_SIZE(BLK), .MEM_WORDS(MW), .INIT_FILE("")) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always @(posedge clk) begin
      if (rst_n && bus.req_valid_i && bus.req_ready_o) acceptEvents++;
   end

   task automatic checkOutput(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rw, input logic unc, input logic [XLEN-1:0] addr,
                                input logic [XLEN/8-1:0] strb, input logic [BLK-1:0] data);
      bus.req_valid_i    = 1'b1;
      bus.req_rw_i       = rw;
      bus.req_uncached_i = unc;
      bus.req_addr_i     = addr;
      bus.req_wstrb_i    = strb;
      bus.req_data_i     = data;
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!bus.req_ready_o && n < 20) begin
         cycle();
         n++;
      end
      if (!bus.req_ready_o) checkOutput({tag, " ready timeout"}, BLK'(0), BLK'(1));
   endtask

   task automatic waitResValid(input string tag, output int lat);
      lat = 1;
      while (!bus.res_valid_o && lat < 40) begin
         cycle();
         lat++;
      end
      if (!bus.res_valid_o) checkOutput({tag, " response timeout"}, BLK'(0), BLK'(1));
   endtask

   // Full transaction: issue, measure cycles from accept to res_valid, check data, handshake.
   task automatic runReq(input string tag, input logic rw, input logic unc, input logic [XLEN-1:0] addr,
                         input logic [XLEN/8-1:0] strb, input logic [BLK-1:0] data,
                         input int expLat, input logic [BLK-1:0] expData);
      int lat;
      applyStimulus(rw, unc, addr, strb, data);
      waitReady(tag);
      cycle();
      bus.req_valid_i = 1'b0;
      waitResValid(tag, lat);
      checkOutput({tag, " latency"}, BLK'(lat), BLK'(expLat));
      checkOutput({tag, " data"}, bus.res_data_o, expData);
      cycle();
   endtask

   logic [XLEN-1:0] t6Addr [4] = '{32'h300, 32'h304, 32'h300, 32'h304};
   logic            t6Rw   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [XLEN-1:0] t6Data [4] = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h0};
   logic [XLEN-1:0] t6Exp  [4] = '{32'h0, 32'h0, 32'hCAFE_0001, 32'hCAFE_0002};

   initial begin
      logic [BLK-1:0] held;
      int             lat;
      int             strayValid;
      int             acceptBase;

      rst_n              = 1'b0;
      bus.req_valid_i    = 1'b0;
      bus.req_rw_i       = 1'b0;
      bus.req_uncached_i = 1'b0;
      bus.req_addr_i     = '0;
      bus.req_wstrb_i    = '0;
      bus.req_data_i     = '0;
      bus.res_ready_i    = 1'b1;
      #12;
      checkOutput("reset req_ready", BLK'(bus.req_ready_o), BLK'(1));
      checkOutput("reset res_valid", BLK'(bus.res_valid_o), BLK'(0));
      checkOutput("reset res_data", bus.res_data_o, '0);
      #10 rst_n = 1'b1;
      cycle();

      $display("[TB] line write then line read");
      runReq("t1 line write", 1'b1, 1'b0, 32'h100, 4'h0, LINE_A, 5, '0);
      runReq("t1 line read", 1'b0, 1'b0, 32'h10C, 4'h0, LINE_A, 6, LINE_A);

      $display("[TB] uncached partial write");
      runReq("t2 uc write full", 1'b1, 1'b1, 32'h204, 4'hF, BLK'(32'hAABB_CCDD), 2, '0);
      runReq("t2 uc write byte1", 1'b1, 1'b1, 32'h204, 4'b0010, BLK'(32'h0000_1100), 2, '0);
      runReq("t2 uc read", 1'b0, 1'b1, 32'h204, 4'h0, '0, 3, BLK'(32'hAABB_11DD));
      runReq("t2 uc write zero strobe", 1'b1, 1'b1, 32'h204, 4'h0, BLK'(32'hFFFF_FFFF), 2, '0);
      runReq("t2 uc read after zero strobe", 1'b0, 1'b1, 32'h204, 4'h0, '0, 3, BLK'(32'hAABB_11DD));

      $display("[TB] response stall with a pending request");
      bus.res_ready_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, '0);
      cycle();
      applyStimulus(1'b0, 1'b1, 32'h204, 4'h0, '0);
      waitResValid("t3 stall", lat);
      held = bus.res_data_o;
      checkOutput("t3 stall data", held, LINE_A);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t3 stall res_valid", BLK'(bus.res_valid_o), BLK'(1));
         checkOutput("t3 stall data stable", bus.res_data_o, LINE_A);
         checkOutput("t3 stall req_ready", BLK'(bus.req_ready_o), BLK'(0));
         cycle();
      end
      bus.res_ready_i = 1'b1;
      cycle();
      checkOutput("t3 idle after handshake", BLK'(bus.req_ready_o), BLK'(1));
      checkOutput("t3 res_valid dropped", BLK'(bus.res_valid_o), BLK'(0));
      cycle();
      checkOutput("t3 accepted next cycle", BLK'(bus.req_ready_o), BLK'(0));
      bus.req_valid_i = 1'b0;
      waitResValid("t3 pending read", lat);
      checkOutput("t3 pending read latency", BLK'(lat), BLK'(3));
      checkOutput("t3 pending read data", bus.res_data_o, BLK'(32'hAABB_11DD));
      cycle();

      $display("[TB] address wrap");
      runReq("t4 wrap write", 1'b1, 1'b1, MW*4 + 32'h8, 4'hF, BLK'(32'h5A5A_1234), 2, '0);
      runReq("t4 wrap read", 1'b0, 1'b1, 32'h8, 4'h0, '0, 3, BLK'(32'h5A5A_1234));

      $display("[TB] reset during line read");
      applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, '0);
      cycle();
      bus.req_valid_i = 1'b0;
      cycle();
      cycle();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5 abort req_ready", BLK'(bus.req_ready_o), BLK'(1));
      checkOutput("t5 abort res_valid", BLK'(bus.res_valid_o), BLK'(0));
      checkOutput("t5 abort res_data", bus.res_data_o, '0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      strayValid = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (bus.res_valid_o) strayValid++;
      end
      checkOutput("t5 no response after abort", BLK'(strayValid), BLK'(0));
      runReq("t5 read after abort", 1'b0, 1'b0, 32'h100, 4'h0, '0, 6, LINE_A);

      $display("[TB] request valid held high");
      acceptBase = acceptEvents;
      applyStimulus(t6Rw[0], 1'b1, t6Addr[0], 4'hF, BLK'(t6Data[0]));
      for (int i = 0; i < 4; i++) begin
         waitReady("t6");
         cycle();
         checkOutput("t6 busy after accept", BLK'(bus.req_ready_o), BLK'(0));
         if (i < 3) applyStimulus(t6Rw[i+1], 1'b1, t6Addr[i+1], 4'hF, BLK'(t6Data[i+1]));
         else bus.req_valid_i = 1'b0;
         waitResValid("t6", lat);
         checkOutput("t6 response data", bus.res_data_o, BLK'(t6Exp[i]));
         cycle();
      end
      checkOutput("t6 accept count", BLK'(acceptEvents - acceptBase), BLK'(4));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
